// File: rtl/spi_master.sv
// spi_master: SPI mode-0 master that shifts one DATA_WIDTH frame MSB first per accepted handshake.
// Latency: 1 setup tick + 2*DATA_WIDTH transfer ticks + 1 hold tick; o_rx_valid pulses on the hold tick.
// Backpressure: o_tx_ready is low while a frame is in flight; SPI_MASTER_BURST_EN allows chaining on the last falling tick.
module spi_master #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_tick,
   input  logic [DATA_WIDTH-1:0] i_tx_data,
   input  logic                  i_tx_valid,
   output logic                  o_tx_ready,
   output logic [DATA_WIDTH-1:0] o_rx_data,
   output logic                  o_rx_valid,
   output logic                  o_sclk,
   output logic                  o_mosi,
   input  logic                  i_miso,
   output logic                  o_cs_n
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SETUP    = 2'd1,
      TRANSFER = 2'd2,
      HOLD     = 2'd3
   } state_t;

   state_t                state;
   logic                  ready_q;
   logic [DATA_WIDTH-1:0] tx_sr;
   logic [DATA_WIDTH-1:0] rx_sr;
   logic [CNT_W-1:0]      cnt;

`ifdef SPI_MASTER_BURST_EN
   // The final falling tick of a frame is the only point where a chained frame may enter.
   logic last_fall;
   assign last_fall  = (state == TRANSFER) && o_sclk && i_tick && (cnt == LAST_BIT);
   assign o_tx_ready = ready_q | last_fall;
`else
   assign o_tx_ready = ready_q;
`endif

   // Frame sequencer: all outputs are registered here; nothing advances outside IDLE without i_tick.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         ready_q    <= 1'b0;
         o_cs_n     <= 1'b1;
         o_sclk     <= 1'b0;
         o_mosi     <= 1'b0;
         o_rx_valid <= 1'b0;
         o_rx_data  <= '0;
         tx_sr      <= '0;
         rx_sr      <= '0;
         cnt        <= '0;
      end else begin
         o_rx_valid <= 1'b0;
         case (state)
            IDLE: begin
               o_cs_n <= 1'b1;
               o_sclk <= 1'b0;
               if (i_tx_valid && ready_q) begin
                  tx_sr   <= i_tx_data;
                  cnt     <= '0;
                  o_mosi  <= i_tx_data[DATA_WIDTH-1];
                  o_cs_n  <= 1'b0;
                  ready_q <= 1'b0;
                  state   <= SETUP;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            SETUP: begin
               // One idle half-period between CS assertion and the first rising edge.
               if (i_tick) begin
                  state <= TRANSFER;
               end
            end
            TRANSFER: begin
               if (i_tick) begin
                  if (!o_sclk) begin
                     o_sclk <= 1'b1;
                     rx_sr  <= {rx_sr[DATA_WIDTH-2:0], i_miso};
                  end else begin
                     o_sclk <= 1'b0;
                     tx_sr  <= tx_sr << 1;
                     o_mosi <= tx_sr[DATA_WIDTH-2];
                     cnt    <= cnt + CNT_W'(1);
                     if (cnt == LAST_BIT) begin
`ifdef SPI_MASTER_BURST_EN
                        if (i_tx_valid) begin
                           // Chained frame: publish the finished word and restart without leaving TRANSFER.
                           tx_sr      <= i_tx_data;
                           o_mosi     <= i_tx_data[DATA_WIDTH-1];
                           cnt        <= '0;
                           o_rx_data  <= rx_sr;
                           o_rx_valid <= 1'b1;
                        end else begin
                           state <= HOLD;
                        end
`else
                        state <= HOLD;
`endif
                     end
                  end
               end
            end
            HOLD: begin
               if (i_tick) begin
                  o_cs_n     <= 1'b1;
                  o_rx_data  <= rx_sr;
                  o_rx_valid <= 1'b1;
                  ready_q    <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: begin
               state   <= IDLE;
               ready_q <= 1'b0;
               o_cs_n  <= 1'b1;
               o_sclk  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: self-checking bench for spi_master with table vectors, corner sequences and random frames.
// Latency: inputs driven on falling clock edges, outputs sampled on falling clock edges.
// Backpressure: the bench waits on o_tx_ready with bounded loops before each handshake.
module tb_spi_master;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         tick = 1'b0;
   logic [W-1:0] tx_data = '0;
   logic         tx_valid = 1'b0;
   logic         tx_ready;
   logic [W-1:0] rx_data;
   logic         rx_valid;
   logic         sclk;
   logic         mosi;
   logic         miso;
   logic         cs_n;

   int   errors = 0;
   int   checks = 0;
   int   tick_period = 4;
   logic tick_en = 1'b1;
   int   tcnt = 0;
   int   miso_mode = 0;   // 0: loopback, 1: tied high, 2: pattern word
   logic pat_bit = 1'b0;

   assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1) ? 1'b1 : pat_bit;

   spi_master #(.DATA_WIDTH(W)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_tick     (tick),
      .i_tx_data  (tx_data),
      .i_tx_valid (tx_valid),
      .o_tx_ready (tx_ready),
      .o_rx_data  (rx_data),
      .o_rx_valid (rx_valid),
      .o_sclk     (sclk),
      .o_mosi     (mosi),
      .i_miso     (miso),
      .o_cs_n     (cs_n)
   );

   always #5 clk = ~clk;

   // Tick source: one pulse every tick_period cycles, changed just after the rising edge.
   always @(posedge clk) begin
      #1;
      if (tick_en) begin
         if (tcnt >= tick_period - 1) begin
            tick = 1'b1;
            tcnt = 0;
         end else begin
            tick = 1'b0;
            tcnt = tcnt + 1;
         end
      end else begin
         tick = 1'b0;
         tcnt = 0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: what the slave side must have returned, from how MISO was driven.
   function automatic logic [W-1:0] model_rx(input logic [W-1:0] tx, input int mode, input logic [W-1:0] word);
      logic [W-1:0] r;
      case (mode)
         0:       r = tx;
         1:       r = '1;
         default: r = word;
      endcase
      return r;
   endfunction

   task automatic wait_ready();
      int waited = 0;
      while (!tx_ready && waited < 300) begin
         @(negedge clk);
         waited++;
      end
   endtask

   task automatic run_frame(input logic [W-1:0] tx, input int mode, input logic [W-1:0] word,
                            input logic [W-1:0] exp_rx, input bit inject, input bit stall, input string name);
      int           waited = 0;
      int           toggles = 0;
      int           rises = 0;
      int           cs_bad = 0;
      int           stall_bad = 0;
      int           extra = 0;
      bit           done = 0;
      bit           inj_done = 0;
      bit           inj_active = 0;
      logic         prev_sclk;
      logic [W-1:0] mosi_bits = '0;

      miso_mode = mode;
      pat_bit   = word[W-1];
      if (stall) tick_en = 1'b0;
      @(negedge clk);
      wait_ready();
      check({name, " ready"}, 32'(tx_ready), 32'd1);
      tx_data  = tx;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data  = ~tx;
      check({name, " cs_low"}, 32'(cs_n), 32'd0);
      if (stall) begin
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cs_n !== 1'b0 || sclk !== 1'b0) stall_bad++;
         end
         check({name, " stall_hold"}, 32'(stall_bad), 32'd0);
         tick_en = 1'b1;
      end
      prev_sclk = sclk;
      while (!done && waited < 2000) begin
         @(negedge clk);
         waited++;
         if (inj_active) begin
            tx_valid   = 1'b0;
            inj_active = 0;
         end
         if (sclk !== prev_sclk) begin
            toggles++;
            if (sclk) begin
               mosi_bits = {mosi_bits[W-2:0], mosi};
               rises++;
               if (rises < W) pat_bit = word[W-1-rises];
            end
         end
         prev_sclk = sclk;
         if (rx_valid) begin
            done = 1;
            check({name, " cs_at_done"}, 32'(cs_n), 32'd1);
         end else if (cs_n !== 1'b0) begin
            cs_bad++;
         end
         if (inject && !inj_done && toggles == 5) begin
            check({name, " busy_ready"}, 32'(tx_ready), 32'd0);
            tx_valid   = 1'b1;
            tx_data    = '1;
            inj_done   = 1;
            inj_active = 1;
         end
      end
      tx_valid = 1'b0;
      check({name, " done"}, 32'(done), 32'd1);
      check({name, " rx"}, 32'(rx_data), 32'(exp_rx));
      check({name, " toggles"}, 32'(toggles), 32'(2 * W));
      check({name, " mosi"}, 32'(mosi_bits), 32'(tx));
      check({name, " cs_frame"}, 32'(cs_bad), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (rx_valid) extra++;
      end
      check({name, " one_pulse"}, 32'(extra), 32'd0);
      check({name, " cs_after"}, 32'(cs_n), 32'd1);
   endtask

   typedef struct {
      logic [W-1:0] tx;
      int           mode;
      logic [W-1:0] word;
      logic [W-1:0] exp_rx;
      bit           inject;
   } vec_t;

   initial begin
      vec_t vecs[6];
      int   hs, pulses, cs_high, toggles, waited, falls, extra;
      bit   pend;
      logic prev_sclk;
      logic [W-1:0] rx1, rx2;

      vecs[0] = '{8'hA5, 0, 8'h00, 8'hA5, 1'b0};
      vecs[1] = '{8'h00, 1, 8'h00, 8'hFF, 1'b0};
      vecs[2] = '{8'h3C, 2, 8'h5A, 8'h5A, 1'b0};
      vecs[3] = '{8'h81, 0, 8'h00, 8'h81, 1'b1};
      vecs[4] = '{8'hFF, 2, 8'h00, 8'h00, 1'b0};
      vecs[5] = '{8'h6E, 2, 8'h93, 8'h93, 1'b1};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst cs_n", 32'(cs_n), 32'd1);
      check("rst sclk", 32'(sclk), 32'd0);
      check("rst mosi", 32'(mosi), 32'd0);
      check("rst ready", 32'(tx_ready), 32'd0);
      check("rst rx_valid", 32'(rx_valid), 32'd0);
      check("rst rx_data", 32'(rx_data), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst ready_rise", 32'(tx_ready), 32'd1);

      // Table vectors
      for (int i = 0; i < 6; i++) begin
         run_frame(vecs[i].tx, vecs[i].mode, vecs[i].word, vecs[i].exp_rx, vecs[i].inject, 1'b0,
                   $sformatf("vec%0d", i));
      end

      // Tick starvation in SETUP, then a normal frame
      run_frame(8'h5A, 0, 8'h00, 8'h5A, 1'b0, 1'b1, "stall");

      // Back-to-back frames with valid held high
      miso_mode = 0;
      @(negedge clk);
      wait_ready();
      tx_data = 8'h3C;
      tx_valid = 1'b1;
      hs = 0; pulses = 0; cs_high = 0; toggles = 0; waited = 0;
      pend = tx_valid && tx_ready;
      rx1 = '0; rx2 = '0;
      prev_sclk = sclk;
      while (pulses < 2 && waited < 2000) begin
         @(negedge clk);
         waited++;
         if (pend) begin
            hs++;
            if (hs == 1) tx_data = 8'hC3;
            else tx_valid = 1'b0;
         end
         pend = tx_valid && tx_ready;
         if (hs >= 1) begin
            if (sclk !== prev_sclk) toggles++;
            if (cs_n === 1'b1 && (pulses == 0 || !rx_valid)) cs_high++;
            if (rx_valid) begin
               if (pulses == 0) rx1 = rx_data;
               else rx2 = rx_data;
               pulses++;
            end
         end
         prev_sclk = sclk;
      end
      tx_valid = 1'b0;
      check("b2b pulses", 32'(pulses), 32'd2);
      check("b2b rx1", 32'(rx1), 32'h3C);
      check("b2b rx2", 32'(rx2), 32'hC3);
      check("b2b toggles", 32'(toggles), 32'd32);
`ifdef SPI_MASTER_BURST_EN
      check("b2b cs_gap", 32'(cs_high), 32'd0);
`else
      check("b2b cs_gap", 32'(cs_high >= 1), 32'd1);
`endif
      repeat (3) @(negedge clk);
      check("b2b cs_after", 32'(cs_n), 32'd1);

      // Reset after the third falling SCLK edge aborts the frame
      miso_mode = 0;
      wait_ready();
      tx_data = 8'hA5;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      falls = 0; waited = 0;
      prev_sclk = sclk;
      while (falls < 3 && waited < 1000) begin
         @(negedge clk);
         waited++;
         if (prev_sclk === 1'b1 && sclk === 1'b0) falls++;
         prev_sclk = sclk;
      end
      check("abort falls", 32'(falls), 32'd3);
      check("abort rx_before", 32'(rx_data), 32'hC3);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort cs_n", 32'(cs_n), 32'd1);
      check("abort sclk", 32'(sclk), 32'd0);
      check("abort rx_valid", 32'(rx_valid), 32'd0);
      check("abort rx_data", 32'(rx_data), 32'd0);
      check("abort mosi", 32'(mosi), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort ready_rise", 32'(tx_ready), 32'd1);
      extra = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (rx_valid || cs_n !== 1'b1) extra++;
      end
      check("abort quiet", 32'(extra), 32'd0);
      check("abort rx_kept", 32'(rx_data), 32'd0);

      // Randomized frames against the reference model
      for (int i = 0; i < 16; i++) begin
         logic [W-1:0] rtx, rword;
         int           rmode;
         rtx         = W'($urandom);
         rword       = W'($urandom);
         rmode       = $urandom_range(0, 2);
         tick_period = $urandom_range(1, 5);
         run_frame(rtx, rmode, rword, model_rx(rtx, rmode, rword), bit'($urandom_range(0, 1)), 1'b0,
                   $sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
